// File: rtl/counter_event_rx.sv
// counter_event_rx: destination-domain receiver for a four-phase req/ack
// event handshake. Synchronizes the request, emits one pulse per accepted
// event, returns the acknowledge level and counts events with wrap or
// saturate behaviour plus a sticky overflow flag.
module counter_event_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16,
  parameter int SATURATE    = 0
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_req,
  output logic             o_ack,
  output logic             o_pulse,
  output logic             o_busy,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow
);

  localparam logic [0:0]       ST_IDLE = 1'b0;
  localparam logic [0:0]       ST_ACK  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [0:0]             state_q, state_d;
  logic                   ack_q, ack_d;
  logic                   pulse_q, pulse_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   req_s;
  logic                   event_w;

  // Synchronizer chain: i_req only ever feeds the first stage.
  assign sync_d[0] = i_req;
  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    assign sync_d[gi] = sync_q[gi-1];
  end
  assign req_s = sync_q[SYNC_STAGES-1];

  // An event is accepted only when a synchronized request is seen in IDLE.
  assign event_w = (state_q == ST_IDLE) && req_s;

  // Handshake FSM: ack follows the next state, pulse marks IDLE->ACK.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_s)  state_d = ST_ACK;
      ST_ACK:  if (!req_s) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ack_d   = (state_d == ST_ACK);
    pulse_d = event_w;
  end

  // Event counter: a clear coinciding with an event still counts that event.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (i_cnt_clr) begin
      ovf_d   = 1'b0;
      count_d = event_w ? CNT_ONE : '0;
    end else if (event_w) begin
      if (count_q == CNT_MAX) begin
        ovf_d   = 1'b1;
        count_d = (SATURATE != 0) ? CNT_MAX : '0;
      end else begin
        count_d = count_q + CNT_ONE;
      end
    end
  end

  // State registers; everything clears asynchronously so ack drops at once.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sync_q  <= '0;
      state_q <= ST_IDLE;
      ack_q   <= 1'b0;
      pulse_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      ack_q   <= ack_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign o_ack      = ack_q;
  assign o_pulse    = pulse_q;
  assign o_busy     = (state_q == ST_ACK);
  assign o_count    = count_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_counter_event_rx.sv
// Bench for counter_event_rx: three instances share stimulus
// (16-bit wrap, 3-bit wrap, 3-bit saturate) and are checked against a
// transaction-level event-count model.
module tb_counter_event_rx;

  logic        i_clk;
  logic        i_rstn;
  logic        i_req;
  logic        i_cnt_clr;
  logic        ack_m, pulse_m, busy_m, ovf_m;
  logic [15:0] count_m;
  logic        ack_w, pulse_w, busy_w, ovf_w;
  logic [2:0]  count_w;
  logic        ack_s, pulse_s, busy_s, ovf_s;
  logic [2:0]  count_s;

  int vectors = 0;
  int miscompares = 0;
  int pulse_total = 0;
  int ev_total = 0;

  // model state
  int m_cnt_m, m_cnt_w, m_cnt_s;
  bit m_ovf_m, m_ovf_w, m_ovf_s;

  counter_event_rx #(.SYNC_STAGES(2), .CNT_W(16), .SATURATE(0)) dut_main (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_req(i_req), .o_ack(ack_m),
    .o_pulse(pulse_m), .o_busy(busy_m), .i_cnt_clr(i_cnt_clr),
    .o_count(count_m), .o_overflow(ovf_m));

  counter_event_rx #(.SYNC_STAGES(2), .CNT_W(3), .SATURATE(0)) dut_wrap (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_req(i_req), .o_ack(ack_w),
    .o_pulse(pulse_w), .o_busy(busy_w), .i_cnt_clr(i_cnt_clr),
    .o_count(count_w), .o_overflow(ovf_w));

  counter_event_rx #(.SYNC_STAGES(2), .CNT_W(3), .SATURATE(1)) dut_sat (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_req(i_req), .o_ack(ack_s),
    .o_pulse(pulse_s), .o_busy(busy_s), .i_cnt_clr(i_cnt_clr),
    .o_count(count_s), .o_overflow(ovf_s));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock, sample 1 time unit after the edge
  task automatic step();
    @(posedge i_clk);
    #1;
    if (pulse_m === 1'b1) pulse_total++;
  endtask

  // model: accepted event, optionally coinciding with a clear
  task automatic model_event(input bit clr);
    ev_total++;
    if (clr) begin
      m_cnt_m = 1; m_cnt_w = 1; m_cnt_s = 1;
      m_ovf_m = 0; m_ovf_w = 0; m_ovf_s = 0;
    end else begin
      if (m_cnt_m == 65535) m_ovf_m = 1;
      m_cnt_m = (m_cnt_m + 1) % 65536;
      if (m_cnt_w == 7) m_ovf_w = 1;
      m_cnt_w = (m_cnt_w + 1) % 8;
      if (m_cnt_s == 7) m_ovf_s = 1;
      else m_cnt_s = m_cnt_s + 1;
    end
  endtask

  task automatic model_clear();
    m_cnt_m = 0; m_cnt_w = 0; m_cnt_s = 0;
    m_ovf_m = 0; m_ovf_w = 0; m_ovf_s = 0;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, ".count_main"}, 32'(count_m), 32'(m_cnt_m));
    chk({tag, ".count_wrap"}, 32'(count_w), 32'(m_cnt_w));
    chk({tag, ".count_sat"},  32'(count_s), 32'(m_cnt_s));
    chk({tag, ".ovf_main"},   32'(ovf_m),   32'(m_ovf_m));
    chk({tag, ".ovf_wrap"},   32'(ovf_w),   32'(m_ovf_w));
    chk({tag, ".ovf_sat"},    32'(ovf_s),   32'(m_ovf_s));
  endtask

  task automatic check_hs(input string tag, input logic exp_ack, input logic exp_pulse);
    chk({tag, ".ack"},   32'(ack_m),   32'(exp_ack));
    chk({tag, ".busy"},  32'(busy_m),  32'(exp_ack));
    chk({tag, ".pulse"}, 32'(pulse_m), 32'(exp_pulse));
    chk({tag, ".ack_wrap"}, 32'(ack_w), 32'(exp_ack));
    chk({tag, ".ack_sat"},  32'(ack_s), 32'(exp_ack));
  endtask

  task automatic do_reset();
    i_rstn = 1'b0; i_req = 1'b0; i_cnt_clr = 1'b0;
    step(); step();
    model_clear();
    check_hs("reset", 1'b0, 1'b0);
    check_counts("reset");
    i_rstn = 1'b1;
    step();
  endtask

  // wait for acceptance with i_req already high; expect 3 edges from E0
  task automatic wait_accept(input string tag, input bit clr_with);
    int n = 0;
    while (ack_m !== 1'b1 && n < 20) begin
      if (n == 2 && clr_with) i_cnt_clr = 1'b1;
      step();
      n++;
      if (n < 3) chk({tag, ".early_ack"}, 32'(ack_m), 32'(1'b0));
    end
    i_cnt_clr = 1'b0;
    model_event(clr_with);
    chk({tag, ".accept_latency"}, 32'(n), 32'd3);
    check_hs({tag, ".accept"}, 1'b1, 1'b1);
    check_counts({tag, ".accept"});
  endtask

  task automatic raise_req(input string tag, input bit clr_with);
    i_req = 1'b1;
    wait_accept(tag, clr_with);
  endtask

  task automatic hold_req(input string tag, input int hold);
    for (int i = 0; i < hold; i++) begin
      step();
      check_hs({tag, ".hold"}, 1'b1, 1'b0);
    end
  endtask

  task automatic release_req(input string tag);
    int n = 0;
    i_req = 1'b0;
    while (ack_m !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    chk({tag, ".release_latency"}, 32'(n), 32'd3);
    check_hs({tag, ".released"}, 1'b0, 1'b0);
  endtask

  task automatic handshake(input string tag, input int hold, input bit clr_with);
    int p0;
    p0 = pulse_total;
    raise_req(tag, clr_with);
    hold_req(tag, hold);
    release_req(tag);
    chk({tag, ".pulses_per_hs"}, 32'(pulse_total - p0), 32'd1);
    check_counts({tag, ".end"});
  endtask

  initial begin
    i_rstn = 1'b0; i_req = 1'b0; i_cnt_clr = 1'b0;
    model_clear();

    // single event, latency and pulse width
    do_reset();
    handshake("single", 1, 1'b0);
    $display("single event: count=%0d", count_m);

    // five handshakes, req held 10 cycles
    do_reset();
    for (int k = 0; k < 5; k++) handshake("five", 9, 1'b0);
    chk("five.total", 32'(count_m), 32'd5);
    $display("five handshakes: count=%0d", count_m);

    // 3-bit wrap/saturate over 8 events
    do_reset();
    for (int k = 0; k < 8; k++) begin
      handshake("wrap8", 2, 1'b0);
      $display("wrap8 event %0d: wrap=%0d sat=%0d ovf=%0b/%0b",
               k + 1, count_w, count_s, ovf_w, ovf_s);
    end
    chk("wrap8.count_wrap_final", 32'(count_w), 32'd0);
    chk("wrap8.count_sat_final", 32'(count_s), 32'd7);
    chk("wrap8.ovf_wrap_final", 32'(ovf_w), 32'd1);

    // clear on the same edge as an event with count=4, overflow=1
    for (int k = 0; k < 4; k++) handshake("pre_clr", 1, 1'b0);
    chk("pre_clr.count_wrap", 32'(count_w), 32'd4);
    chk("pre_clr.ovf_wrap", 32'(ovf_w), 32'd1);
    handshake("clr_evt", 1, 1'b1);
    chk("clr_evt.count_wrap", 32'(count_w), 32'd1);
    chk("clr_evt.ovf_wrap", 32'(ovf_w), 32'd0);
    $display("clear with event: count=%0d ovf=%0b", count_w, ovf_w);

    // clear while idle
    i_cnt_clr = 1'b1;
    step();
    i_cnt_clr = 1'b0;
    model_clear();
    check_counts("idle_clr");

    // reset mid-handshake with req still high
    raise_req("midrst", 1'b0);
    step();
    #1 i_rstn = 1'b0;
    #1;
    model_clear();
    check_hs("midrst.in_reset", 1'b0, 1'b0);
    check_counts("midrst.in_reset");
    #1 i_rstn = 1'b1;
    wait_accept("midrst.reack", 1'b0);
    chk("midrst.count", 32'(count_m), 32'd1);
    hold_req("midrst", 2);
    release_req("midrst");
    $display("reset mid-handshake: re-acked, count=%0d", count_m);

    // randomized sender, 1000 events
    for (int k = 0; k < 1000; k++) begin
      int hold, gap, sel;
      hold = $urandom_range(0, 8);
      gap  = $urandom_range(0, 4);
      sel  = $urandom_range(0, 15);
      for (int g = 0; g < gap; g++) step();
      if (sel == 1) begin
        i_cnt_clr = 1'b1;
        step();
        i_cnt_clr = 1'b0;
        model_clear();
        check_counts("rand.idle_clr");
      end
      handshake("rand", hold, sel == 0);
      if (k % 100 == 99)
        $display("random event %0d: count=%0d model=%0d", k + 1, count_m, m_cnt_m);
    end
    chk("rand.pulse_total", 32'(pulse_total), 32'(ev_total));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_event_rx.md
# counter_event_rx

Receive end of the four-phase level req/ack handshake used to move single events across clock domains into a counter. The sender holds a request level in its own domain until it sees the acknowledge. This block runs entirely in the destination domain. It synchronizes the incoming request, converts each accepted request into a one-cycle pulse and drives the acknowledge level back. It also accumulates accepted events in a clearable counter with wrap or saturate behaviour and a sticky overflow flag.

## Interface
- SYNC_STAGES, 2, number of synchronizer flops on i_req; legal range 2..4.
- CNT_W, 16, event counter width; legal range 1..32.
- SATURATE, 0, 0 = counter wraps to 0 past all-ones; 1 = counter holds at all-ones.
- i_clk  input  1  destination-domain clock; all logic on posedge.
- i_rstn  input  1  asynchronous active-low reset; assertion is asynchronous, and the block is in reset while low.
- i_req  input  1  request level from the sender domain, asynchronous to i_clk.
- o_ack  output  1  acknowledge level back to the sender, registered.
- o_pulse  output  1  one-cycle strobe per accepted event, registered.
- o_busy  output  1  high while the FSM is in ACK.
- i_cnt_clr  input  1  synchronous counter clear, sampled every cycle.
- o_count  output  CNT_W  accepted-event count, registered.
- o_overflow  output  1  sticky; set when an event arrives with o_count at all-ones.

## Operation
- Synchronizer:
  - i_req passes through SYNC_STAGES flops; req_s is the last stage.
  - No logic reads i_req before the first stage.
- FSM, two states; reset state IDLE:
  - IDLE, req_s=1 → ACK. On that edge: o_ack←1, o_pulse←1, the counter updates, and o_busy is 1 next cycle.
  - IDLE, req_s=0 → stay in IDLE.
  - ACK, req_s=0 → IDLE. On that edge o_ack←0.
  - ACK, req_s=1 → stay in ACK; o_pulse←0.
- o_pulse is 1 only in the cycle immediately after an IDLE→ACK transition.
- o_ack equals (state==ACK), registered.
- Counter update priority at each edge:
  - i_cnt_clr=1 with no event: o_count←0 and o_overflow←0.
  - i_cnt_clr=1 with an event on the same edge: o_count←1 and o_overflow←0. The event is not lost.
  - Event with o_count < all-ones: o_count←o_count+1.
  - Event with o_count = all-ones: o_overflow←1. o_count←0 if SATURATE=0, otherwise it holds all-ones.
- Reset values: o_ack=0, o_pulse=0, o_busy=0, o_count=0, o_overflow=0, all synchronizer flops 0, FSM in IDLE.
- Reset mid-handshake:
  - All state is cleared and o_ack drops asynchronously.
  - If i_req is still high after release, the block treats it as a new event: it is re-acknowledged and counted again.
  - Sender-side recovery is outside this block.
- A req pulse shorter than the synchronizer capture window is not guaranteed to be seen. The sender must hold req until ack, so this is a protocol violation and is not handled.

## Timing
- Let E0 be the first posedge that samples i_req=1.
- Forward path:
  - req_s=1 after edge E(SYNC_STAGES−1).
  - o_ack, o_pulse, o_busy and the updated o_count are all visible after edge E(SYNC_STAGES). Latency is SYNC_STAGES+1 edges, including E0.
  - o_pulse is high for exactly 1 cycle.
- Release path: from the first edge sampling i_req=0, o_ack falls after SYNC_STAGES+1 edges.
- Minimum complete handshake, rise-to-rise with an ideal sender: 2×(SYNC_STAGES+1) destination cycles plus the sender-domain sync latency.
- Back-to-back events: a new req rise is accepted only after the FSM has returned to IDLE. At most one o_pulse per full handshake.
- i_cnt_clr has single-cycle effect: o_count shows the cleared value after the edge that samples it.

## Test plan
- Reset with i_req=0, then raise i_req (SYNC_STAGES=2). Required: o_ack, o_pulse and o_busy rise on the 3rd edge after E0; o_pulse lasts 1 cycle; o_count=1. Drop i_req: o_ack falls 3 edges later.
- 5 full handshakes with i_req held 10 cycles each. Required: o_count=5, exactly 5 single-cycle o_pulse, o_ack tracks i_req delayed by 3 edges.
- CNT_W=3, SATURATE=0, 8 events. Required: o_count goes 1..7 then 0; o_overflow=1 after the 8th. With SATURATE=1: o_count stays 7 and o_overflow=1.
- i_cnt_clr asserted on the same edge as an event, with o_count=4 and o_overflow=1. Required: o_count=1, o_overflow=0.
- i_rstn pulsed low while in ACK with i_req held high. Required: o_ack=0 and o_count=0 immediately; after release the block re-acks after 3 edges and o_count=1.
- Randomized sender holding req until ack and releasing until ack drops, 1000 events. Required: o_count = event count, never more than one o_pulse per handshake.
